miriscv_imm_pipe: RTL and testbench
===================================

// Module: miriscv_imm_pipe
// PURPOSE
//  Pipelined immediate/target stage placed between fetch and decode.
//  Extracts the sign-extended immediate for all RV32I/RV64I base formats and classifies the format.
//  Flags illegal encodings and precomputes pc+imm (branch, JAL, AUIPC target).
//  Valid/ready on both sides, 1-cycle latency, optional 2-entry skid buffer for full throughput.
// PARAMETERS
//  XLEN  32  datapath width; 32 or 64 only (64 enables OP-IMM-32/OP-32 opcodes)
//  SKID  1   1: 2-entry skid buffer, in_ready_o registered; 0: single register, in_ready_o = !out_valid_o | out_ready_i
// PORTS
//  clk_i        in   1     clock, all state on rising edge
//  rstn_i       in   1     synchronous reset, active low
//  flush_i      in   1     drop all buffered entries
//  in_valid_i   in   1     instruction presented
//  in_ready_o   out  1     stage can accept
//  instr_i      in   32    raw instruction word
//  pc_i         in   XLEN  instruction address
//  out_valid_o  out  1     result valid
//  out_ready_i  in   1     consumer accepts
//  instr_o      out  32    passthrough of instr_i
//  pc_o         out  XLEN  passthrough of pc_i
//  imm_o        out  XLEN  sign-extended immediate (0 for R-type/illegal)
//  fmt_o        out  3     0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J
//  illegal_o    out  1     unsupported encoding
//  target_o     out  XLEN  pc_i + imm_o, modulo 2^XLEN
// BEHAVIOUR
//  - Reset (rstn_i=0 at edge): out_valid_o=0; instr_o, pc_o, imm_o, target_o = 0; fmt_o=0; illegal_o=0; both skid entries empty.
//    in_ready_o=0 while rstn_i=0, 1 in first cycle after release. Reset mid-transfer discards all contents; nothing is replayed.
//  - Transfer occurs when valid&ready are high at a clock edge.
//    Accepted word appears on outputs at the next edge (latency 1) if the output register is free.
//  - Decode uses op=instr_i[6:2]:
//    I: LOAD 00000, MISC-MEM 00011, OP-IMM 00100, JALR 11001, SYSTEM 11100, OP-IMM-32 00110 (XLEN=64).
//    S: STORE 01000. B: BRANCH 11000. U: LUI 01101, AUIPC 00101. J: JAL 11011.
//    R: OP 01100, OP-32 01110 (XLEN=64).
//  - Immediate bits: I {i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],0};
//    U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}.
//    Sign-extend from the top bit to XLEN (U-type sign-extends bit 31 when XLEN=64).
//  - illegal_o=1 when instr_i[1:0]!=2'b11 or op is not listed for the configured XLEN; then fmt_o=0, imm_o=0, target_o=pc_i.
//  - target_o is computed for every entry regardless of format; wrap-around discarded.
//  - SKID=1: entries are out register (E0) and skid (E1).
//    in_ready_o = !E1_full, registered. If out stalls while input accepted, the word lands in E1.
//    When E0 is taken, E1 moves to E0. Order is strictly FIFO.
//    Input and output may handshake in the same cycle; occupancy then stays unchanged.
//  - SKID=0: single entry; in_ready_o combinational from out_ready_i; same-cycle pop+push allowed.
//  - flush_i=1: all entries invalidated at the edge; the same-cycle input handshake is discarded; in_ready_o=1 next cycle.
//    flush_i has priority over in_valid_i and out_ready_i; rstn_i has priority over flush_i.
//  - Outputs are stable while out_valid_o=1 and out_ready_i=0. out_valid_o never drops without a handshake or flush.
// TESTING
//  1. XLEN=32, pc=0x100, 0xFFF00093 (addi x1,x0,-1) -> imm 0xFFFFFFFF, fmt 1, target 0xFF, out_valid_o one cycle later.
//  2. 0xFFDFF06F (jal x0,-4) pc=0x100 -> imm 0xFFFFFFFC, fmt 5, target 0xFC.
//     0x00000463 (beq +8) -> imm 8, fmt 3, target 0x108.
//  3. XLEN=64, 0x800000B7 (lui x1,0x80000) -> imm 0xFFFFFFFF80000000, fmt 4.
//     0x0000001B (OP-IMM-32) legal; same word with XLEN=32 -> illegal_o=1, imm 0.
//  4. SKID=1: stream 4 words, out_ready_i=0 for 3 cycles -> exactly 2 accepted, in_ready_o=0.
//     Release -> words emerge in order, no loss or duplication.
//  5. Two entries buffered, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed and same-cycle words never emerge.
//  6. rstn_i=0 for 1 cycle with both entries full -> all outputs zero, out_valid_o=0; in_ready_o=1 after release.

Source files
------------

// File: rtl/miriscv_imm_pipe.sv
// Immediate/target stage between fetch and decode.
// Decodes format + immediate, precomputes pc+imm, 1- or 2-entry buffer.
module miriscv_imm_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] target_o
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic [2:0]      fmt;
        logic            ill;
    } ent_t;

    logic [4:0]      w_op;
    logic            w_quad;
    logic            w_rv64;
    logic            w_is_i;
    logic            w_is_s;
    logic            w_is_b;
    logic            w_is_u;
    logic            w_is_j;
    logic            w_is_r;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    ent_t            w_new;

    logic            w_push;
    logic            w_pop;
    logic            w_e0_v_n;
    logic            w_e1_v_n;
    logic            w_ld0_new;
    logic            w_ld0_e1;
    logic            w_ld1_new;

    ent_t            r_e0;
    ent_t            r_e1;
    logic            r_e0_v;
    logic            r_e1_v;
    logic            r_alive;
    logic            r_rdy;

    assign w_op   = instr_i[6:2];
    assign w_quad = (instr_i[1:0] == 2'b11);
    assign w_rv64 = (XLEN == 64);

    assign w_is_i = (w_op == 5'b00000) || (w_op == 5'b00011) ||
                    (w_op == 5'b00100) || (w_op == 5'b11001) ||
                    (w_op == 5'b11100) ||
                    (w_rv64 && (w_op == 5'b00110));
    assign w_is_s = (w_op == 5'b01000);
    assign w_is_b = (w_op == 5'b11000);
    assign w_is_u = (w_op == 5'b01101) || (w_op == 5'b00101);
    assign w_is_j = (w_op == 5'b11011);
    assign w_is_r = (w_op == 5'b01100) ||
                    (w_rv64 && (w_op == 5'b01110));

    // Format classification and sign-extended immediate of the incoming word
    always_comb begin
        w_fmt = FMT_R;
        w_ill = 1'b0;
        w_imm = '0;
        if (!w_quad) begin
            w_ill = 1'b1;
        end else begin
            unique case (1'b1)
                w_is_i: begin
                    w_fmt = FMT_I;
                    w_imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
                end
                w_is_s: begin
                    w_fmt = FMT_S;
                    w_imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:25],
                             instr_i[11:7]};
                end
                w_is_b: begin
                    w_fmt = FMT_B;
                    w_imm = {{(XLEN-12){instr_i[31]}}, instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                end
                w_is_u: begin
                    w_fmt = FMT_U;
                    w_imm = {{(XLEN-31){instr_i[31]}}, instr_i[30:12],
                             12'b0};
                end
                w_is_j: begin
                    w_fmt = FMT_J;
                    w_imm = {{(XLEN-20){instr_i[31]}}, instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
                end
                w_is_r: begin
                    w_fmt = FMT_R;
                end
                default: begin
                    w_ill = 1'b1;
                end
            endcase
        end
    end

    assign w_new.instr = instr_i;
    assign w_new.pc    = pc_i;
    assign w_new.imm   = w_imm;
    assign w_new.tgt   = pc_i + w_imm;
    assign w_new.fmt   = w_fmt;
    assign w_new.ill   = w_ill;

    assign in_ready_o = (SKID != 0) ? r_rdy
                                    : (r_alive & (!r_e0_v | out_ready_i));
    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = r_e0_v & out_ready_i;

    // Next occupancy and entry moves; E1 only fills when E0 is stalled
    always_comb begin
        w_e0_v_n  = r_e0_v;
        w_e1_v_n  = r_e1_v;
        w_ld0_new = 1'b0;
        w_ld0_e1  = 1'b0;
        w_ld1_new = 1'b0;
        if (flush_i) begin
            w_e0_v_n = 1'b0;
            w_e1_v_n = 1'b0;
        end else if (w_pop) begin
            if (r_e1_v) begin
                w_ld0_e1  = 1'b1;
                w_e1_v_n  = w_push;
                w_ld1_new = w_push;
            end else begin
                w_e0_v_n  = w_push;
                w_ld0_new = w_push;
            end
        end else if (w_push) begin
            if (!r_e0_v) begin
                w_e0_v_n  = 1'b1;
                w_ld0_new = 1'b1;
            end else begin
                w_e1_v_n  = 1'b1;
                w_ld1_new = 1'b1;
            end
        end
        if (SKID == 0) begin
            w_e1_v_n  = 1'b0;
            w_ld1_new = 1'b0;
        end
    end

    // Entry registers, valid bits and the registered ready
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_e0_v  <= 1'b0;
            r_e1_v  <= 1'b0;
            r_alive <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_e0_v  <= w_e0_v_n;
            r_e1_v  <= w_e1_v_n;
            r_alive <= 1'b1;
            r_rdy   <= !w_e1_v_n;
            if (w_ld0_new) begin
                r_e0 <= w_new;
            end else if (w_ld0_e1) begin
                r_e0 <= r_e1;
            end
            if (w_ld1_new) begin
                r_e1 <= w_new;
            end
        end
    end

    assign out_valid_o = r_e0_v;
    assign instr_o     = r_e0.instr;
    assign pc_o        = r_e0.pc;
    assign imm_o       = r_e0.imm;
    assign fmt_o       = r_e0.fmt;
    assign illegal_o   = r_e0.ill;
    assign target_o    = r_e0.tgt;

endmodule

// File: tb/tb_miriscv_imm_pipe.sv
// Bench for miriscv_imm_pipe: three configurations on shared stimulus,
// directed vectors, handshake corner cases and a random run vs a model.
module tb_miriscv_imm_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_rdy, a_v, a_ill;
    logic [31:0] a_ins, a_pc, a_imm, a_tgt;
    logic [2:0]  a_fmt;
    logic        b_rdy, b_v, b_ill;
    logic [31:0] b_ins;
    logic [63:0] b_pc, b_imm, b_tgt;
    logic [2:0]  b_fmt;
    logic        c_rdy, c_v, c_ill;
    logic [31:0] c_ins, c_pc, c_imm, c_tgt;
    logic [2:0]  c_fmt;

    miriscv_imm_pipe #(.XLEN(32), .SKID(1)) u_a (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_rdy),
        .instr_i(instr), .pc_i(pc[31:0]),
        .out_valid_o(a_v), .out_ready_i(out_ready),
        .instr_o(a_ins), .pc_o(a_pc), .imm_o(a_imm),
        .fmt_o(a_fmt), .illegal_o(a_ill), .target_o(a_tgt)
    );

    miriscv_imm_pipe #(.XLEN(64), .SKID(1)) u_b (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_rdy),
        .instr_i(instr), .pc_i(pc),
        .out_valid_o(b_v), .out_ready_i(out_ready),
        .instr_o(b_ins), .pc_o(b_pc), .imm_o(b_imm),
        .fmt_o(b_fmt), .illegal_o(b_ill), .target_o(b_tgt)
    );

    miriscv_imm_pipe #(.XLEN(32), .SKID(0)) u_c (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(c_rdy),
        .instr_i(instr), .pc_i(pc[31:0]),
        .out_valid_o(c_v), .out_ready_i(out_ready),
        .instr_o(c_ins), .pc_o(c_pc), .imm_o(c_imm),
        .fmt_o(c_fmt), .illegal_o(c_ill), .target_o(c_tgt)
    );

    logic [63:0] o_pc[3], o_imm[3], o_tgt[3];
    logic [31:0] o_ins[3];
    logic [2:0]  o_fmt[3];
    logic        o_v[3], o_rdy[3], o_ill[3];

    assign o_pc[0]  = {32'd0, a_pc};
    assign o_imm[0] = {32'd0, a_imm};
    assign o_tgt[0] = {32'd0, a_tgt};
    assign o_ins[0] = a_ins;
    assign o_fmt[0] = a_fmt;
    assign o_v[0]   = a_v;
    assign o_rdy[0] = a_rdy;
    assign o_ill[0] = a_ill;
    assign o_pc[1]  = b_pc;
    assign o_imm[1] = b_imm;
    assign o_tgt[1] = b_tgt;
    assign o_ins[1] = b_ins;
    assign o_fmt[1] = b_fmt;
    assign o_v[1]   = b_v;
    assign o_rdy[1] = b_rdy;
    assign o_ill[1] = b_ill;
    assign o_pc[2]  = {32'd0, c_pc};
    assign o_imm[2] = {32'd0, c_imm};
    assign o_tgt[2] = {32'd0, c_tgt};
    assign o_ins[2] = c_ins;
    assign o_fmt[2] = c_fmt;
    assign o_v[2]   = c_v;
    assign o_rdy[2] = c_rdy;
    assign o_ill[2] = c_ill;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } ent_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        bit          x64;
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    int   xl[3] = '{32, 64, 32};
    bit   sk[3] = '{1'b1, 1'b1, 1'b0};
    ent_t mb[3][2];
    int   mcnt[3];
    bit   alive[3];
    bit   lpush[3];
    int   dacc[3];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] got[$];
    logic [6:0]  opc[16] = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73, 7'h1B,
                             7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
                             7'h3B, 7'h0B, 7'h10, 7'h7E};

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] msk(int k);
        return (xl[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                             : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference decode from the 7-bit opcode and plain integer arithmetic
    function automatic exp_t ref_dec(logic [31:0] ins, logic [63:0] pcv,
                                     int xw);
        exp_t        e;
        longint      v;
        logic [63:0] m;
        m = (xw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h1B: if (xw == 64) e.fmt = 3'd1; else e.ill = 1'b1;
            7'h23: e.fmt = 3'd2;
            7'h63: e.fmt = 3'd3;
            7'h37, 7'h17: e.fmt = 3'd4;
            7'h6F: e.fmt = 3'd5;
            7'h33: e.fmt = 3'd0;
            7'h3B: if (xw != 64) e.ill = 1'b1;
            default: e.ill = 1'b1;
        endcase
        case (e.fmt)
            3'd1: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3'd3: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd4: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(ins[31]) * 1048576 +
                    longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        e.imm = 64'(v) & m;
        e.tgt = (pcv + 64'(v)) & m;
        return e;
    endfunction

    function automatic bit exp_rdy(int k);
        if (!alive[k]) return 1'b0;
        if (sk[k]) return mcnt[k] < 2;
        return (mcnt[k] == 0) || out_ready;
    endfunction

    // Compare all instances against the model, then advance the model
    task automatic tick_check();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bit   r;
            bit   push;
            bit   pop;
            exp_t d;
            r = exp_rdy(k);
            chk($sformatf("u%0d.valid", k), 64'(o_v[k]), 64'(mcnt[k] > 0));
            chk($sformatf("u%0d.ready", k), 64'(o_rdy[k]), 64'(r));
            if (mcnt[k] > 0) begin
                d = ref_dec(mb[k][0].ins, mb[k][0].pc, xl[k]);
                chk($sformatf("u%0d.instr", k), 64'(o_ins[k]),
                    64'(mb[k][0].ins));
                chk($sformatf("u%0d.pc", k), o_pc[k], mb[k][0].pc & msk(k));
                chk($sformatf("u%0d.imm", k), o_imm[k], d.imm);
                chk($sformatf("u%0d.fmt", k), 64'(o_fmt[k]), 64'(d.fmt));
                chk($sformatf("u%0d.ill", k), 64'(o_ill[k]), 64'(d.ill));
                chk($sformatf("u%0d.tgt", k), o_tgt[k], d.tgt);
            end
            if (k == 0 && o_v[0] && out_ready) got.push_back(o_ins[0]);
            if (in_valid && o_rdy[k]) dacc[k]++;
            push = in_valid && r;
            pop  = (mcnt[k] > 0) && out_ready;
            lpush[k] = push && rstn && !flush;
            if (!rstn) begin
                mcnt[k]  = 0;
                alive[k] = 1'b0;
            end else if (flush) begin
                mcnt[k]  = 0;
                alive[k] = 1'b1;
            end else begin
                if (pop) begin
                    mb[k][0] = mb[k][1];
                    mcnt[k]--;
                end
                if (push) begin
                    mb[k][mcnt[k]].ins = instr;
                    mb[k][mcnt[k]].pc  = pc;
                    mcnt[k]++;
                end
                alive[k] = 1'b1;
            end
        end
    endtask

    task automatic tick_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick_check();
        tick_adv();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        w = $urandom;
        w[6:0] = opc[$urandom_range(0, 15)];
        return w;
    endfunction

    vec_t        vt[15];
    logic [31:0] ws[4];
    int          idx;
    int          a0;
    int          k;

    initial begin
        vt[0]  = '{0, 32'hFFF00093, 64'h100, 64'hFFFFFFFF, 64'hFF, 3'd1, 1'b0};
        vt[1]  = '{1, 32'hFFF00093, 64'h100, 64'hFFFFFFFF_FFFFFFFF, 64'hFF, 3'd1, 1'b0};
        vt[2]  = '{0, 32'hFFDFF06F, 64'h100, 64'hFFFFFFFC, 64'hFC, 3'd5, 1'b0};
        vt[3]  = '{0, 32'h00000463, 64'h100, 64'h8, 64'h108, 3'd3, 1'b0};
        vt[4]  = '{1, 32'h800000B7, 64'h100, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000100, 3'd4, 1'b0};
        vt[5]  = '{0, 32'h800000B7, 64'h100, 64'h80000000, 64'h80000100, 3'd4, 1'b0};
        vt[6]  = '{1, 32'h0000001B, 64'h100, 64'h0, 64'h100, 3'd1, 1'b0};
        vt[7]  = '{0, 32'h0000001B, 64'h100, 64'h0, 64'h100, 3'd0, 1'b1};
        vt[8]  = '{0, 32'h00112623, 64'h100, 64'hC, 64'h10C, 3'd2, 1'b0};
        vt[9]  = '{0, 32'h00000010, 64'h100, 64'h0, 64'h100, 3'd0, 1'b1};
        vt[10] = '{0, 32'h002081B3, 64'h100, 64'h0, 64'h100, 3'd0, 1'b0};
        vt[11] = '{0, 32'h12345097, 64'h100, 64'h12345000, 64'h12345100, 3'd4, 1'b0};
        vt[12] = '{1, 32'hFFDFF06F, 64'h0, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0};
        vt[13] = '{0, 32'h00000463, 64'hFFFFFFFC, 64'h8, 64'h4, 3'd3, 1'b0};
        vt[14] = '{0, 32'h00000073, 64'h200, 64'h0, 64'h200, 3'd1, 1'b0};
        ws = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};

        rstn = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        instr = '0;
        pc = '0;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            alive[i] = 1'b0;
            dacc[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d.valid", i), 64'(o_v[i]), 64'd0);
            chk($sformatf("rst%0d.ready", i), 64'(o_rdy[i]), 64'd0);
            chk($sformatf("rst%0d.instr", i), 64'(o_ins[i]), 64'd0);
            chk($sformatf("rst%0d.pc", i), o_pc[i], 64'd0);
            chk($sformatf("rst%0d.imm", i), o_imm[i], 64'd0);
            chk($sformatf("rst%0d.tgt", i), o_tgt[i], 64'd0);
            chk($sformatf("rst%0d.fmt", i), 64'(o_fmt[i]), 64'd0);
            chk($sformatf("rst%0d.ill", i), 64'(o_ill[i]), 64'd0);
        end
        rstn = 1'b1;
        step();

        // directed vectors, one word at a time, result one cycle later
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            instr = vt[i].ins;
            pc = vt[i].pc;
            step();
            in_valid = 1'b0;
            tick_check();
            k = vt[i].x64 ? 1 : 0;
            chk($sformatf("vec%0d.valid", i), 64'(o_v[k]), 64'd1);
            chk($sformatf("vec%0d.imm", i), o_imm[k], vt[i].imm);
            chk($sformatf("vec%0d.fmt", i), 64'(o_fmt[k]), 64'(vt[i].fmt));
            chk($sformatf("vec%0d.ill", i), 64'(o_ill[k]), 64'(vt[i].ill));
            chk($sformatf("vec%0d.tgt", i), o_tgt[k], vt[i].tgt);
            tick_adv();
        end

        // output stalled three cycles while four words are offered
        got.delete();
        out_ready = 1'b0;
        idx = 0;
        a0 = dacc[0];
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            instr = ws[idx];
            pc = 64'h1000 + 64'(4 * idx);
            tick_check();
            if (lpush[0]) idx++;
            if (c == 3) begin
                chk("stall.accepted", 64'(dacc[0] - a0), 64'd2);
                chk("stall.ready", 64'(o_rdy[0]), 64'd0);
            end
            tick_adv();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                instr = ws[idx];
                pc = 64'h1000 + 64'(4 * idx);
            end
            tick_check();
            if (lpush[0]) idx++;
            tick_adv();
        end
        in_valid = 1'b0;
        chk("stream.count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size())
                chk($sformatf("stream.word%0d", i), 64'(got[i]), 64'(ws[i]));
        end

        // flush with both entries full and a word offered
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00A00093;
        pc = 64'h2000;
        step();
        instr = 32'h00B00093;
        pc = 64'h2004;
        step();
        flush = 1'b1;
        instr = 32'h00C00093;
        pc = 64'h2008;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick_check();
        chk("flush.valid", 64'(o_v[0]), 64'd0);
        chk("flush.ready", 64'(o_rdy[0]), 64'd1);
        tick_adv();
        for (int c = 0; c < 3; c++) begin
            tick_check();
            chk($sformatf("flush.gone%0d", c), 64'(o_v[0]), 64'd0);
            tick_adv();
        end

        // reset for one cycle with both entries full
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'h00D00093;
        pc = 64'h3000;
        step();
        instr = 32'h00E00093;
        pc = 64'h3004;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        in_valid = 1'b0;
        tick_check();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst6.%0d.valid", i), 64'(o_v[i]), 64'd0);
            chk($sformatf("rst6.%0d.instr", i), 64'(o_ins[i]), 64'd0);
            chk($sformatf("rst6.%0d.imm", i), o_imm[i], 64'd0);
            chk($sformatf("rst6.%0d.tgt", i), o_tgt[i], 64'd0);
            chk($sformatf("rst6.%0d.pc", i), o_pc[i], 64'd0);
        end
        tick_adv();
        tick_check();
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst6.%0d.ready", i), 64'(o_rdy[i]), 64'd1);
        tick_adv();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rstn = ($urandom_range(0, 199) != 0);
            instr = rand_ins();
            pc = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
